// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus iterative MUL/DIVU/REMU, registering
// the result, NZCV flags and forwarded control into the execute/memory boundary.
module execute_stage #(
    parameter int XLEN    = 64,
    parameter int ITER    = 64,
    parameter int WADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               in_valid,
    input  logic [XLEN-1:0]    operand_a,
    input  logic [XLEN-1:0]    operand_b,
    input  logic [7:0]         aluop,
    input  logic               regwrite,
    input  logic               memwrite,
    input  logic               memtoreg,
    input  logic               branch,
    input  logic               setflags,
    input  logic [WADDR_W-1:0] write_addr,
    output logic               stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_result,
    output logic [XLEN-1:0]    ex_store_data,
    output logic               ex_regwrite,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_branch,
    output logic [WADDR_W-1:0] ex_write_addr,
    output logic [3:0]         flags
);
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int SH_W  = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_AND  = 8'h02;
    localparam logic [7:0] OP_OR   = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_SHL  = 8'h05;
    localparam logic [7:0] OP_SHR  = 8'h06;
    localparam logic [7:0] OP_SAR  = 8'h07;
    localparam logic [7:0] OP_MUL  = 8'h08;
    localparam logic [7:0] OP_DIVU = 8'h09;
    localparam logic [7:0] OP_REMU = 8'h0A;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // acc: product accumulator (MUL) or partial remainder (DIVU/REMU)
    logic [XLEN-1:0]    acc_q, acc_d;
    // a: shifting multiplicand (MUL) or dividend/quotient (DIVU/REMU)
    logic [XLEN-1:0]    a_q, a_d;
    // b: shifting multiplier (MUL) or divisor (DIVU/REMU)
    logic [XLEN-1:0]    b_q, b_d;
    logic [XLEN-1:0]    store_q, store_d;
    logic [7:0]         op_q, op_d;
    logic               rw_q, rw_d, mw_q, mw_d, mtr_q, mtr_d, br_q, br_d, sf_q, sf_d;
    logic [WADDR_W-1:0] wa_q, wa_d;

    logic               ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]    ex_result_q, ex_result_d;
    logic [XLEN-1:0]    ex_store_q, ex_store_d;
    logic               ex_rw_q, ex_rw_d, ex_mw_q, ex_mw_d, ex_mtr_q, ex_mtr_d, ex_br_q, ex_br_d;
    logic [WADDR_W-1:0] ex_wa_q, ex_wa_d;
    logic [3:0]         flags_q, flags_d;

    logic               is_multi;
    logic [SH_W-1:0]    shamt;
    logic [XLEN:0]      sum_w, diff_w;
    logic [XLEN-1:0]    alu_res;
    logic               alu_c, alu_v;
    logic [XLEN:0]      rem_shift;
    logic [XLEN-1:0]    rem_sub;
    logic               rem_ge;
    logic [XLEN-1:0]    final_res;

    assign is_multi = (aluop == OP_MUL) || (aluop == OP_DIVU) || (aluop == OP_REMU);
    assign shamt    = operand_b[SH_W-1:0];
    assign stall    = halt || (state_q == ST_IDLE && in_valid && is_multi) || (state_q == ST_BUSY);

    always_comb begin
        sum_w   = {1'b0, operand_a} + {1'b0, operand_b};
        diff_w  = {1'b0, operand_a} - {1'b0, operand_b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (aluop)
            OP_ADD: begin
                alu_res = sum_w[XLEN-1:0];
                alu_c   = sum_w[XLEN];
                alu_v   = (operand_a[XLEN-1] == operand_b[XLEN-1]) &&
                          (sum_w[XLEN-1] != operand_a[XLEN-1]);
            end
            OP_SUB: begin
                alu_res = diff_w[XLEN-1:0];
                alu_c   = ~diff_w[XLEN];
                alu_v   = (operand_a[XLEN-1] != operand_b[XLEN-1]) &&
                          (diff_w[XLEN-1] != operand_a[XLEN-1]);
            end
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_SHL:  alu_res = operand_a << shamt;
            OP_SHR:  alu_res = operand_a >> shamt;
            OP_SAR:  alu_res = $unsigned($signed(operand_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Restoring divide step; with a zero divisor every step "fits", which
    // naturally yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        rem_shift = {acc_q, a_q[XLEN-1]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_sub   = rem_shift[XLEN-1:0] - b_q;
    end

    assign final_res = (op_q == OP_DIVU) ? a_q : acc_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        store_d     = store_q;
        op_d        = op_q;
        rw_d        = rw_q;
        mw_d        = mw_q;
        mtr_d       = mtr_q;
        br_d        = br_q;
        sf_d        = sf_q;
        wa_d        = wa_q;
        ex_valid_d  = ex_valid_q;
        ex_result_d = ex_result_q;
        ex_store_d  = ex_store_q;
        ex_rw_d     = ex_rw_q;
        ex_mw_d     = ex_mw_q;
        ex_mtr_d    = ex_mtr_q;
        ex_br_d     = ex_br_q;
        ex_wa_d     = ex_wa_q;
        flags_d     = flags_q;
        if (!halt) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && is_multi) begin
                        a_d        = operand_a;
                        b_d        = operand_b;
                        store_d    = operand_b;
                        acc_d      = '0;
                        cnt_d      = '0;
                        op_d       = aluop;
                        rw_d       = regwrite;
                        mw_d       = memwrite;
                        mtr_d      = memtoreg;
                        br_d       = branch;
                        sf_d       = setflags;
                        wa_d       = write_addr;
                        ex_valid_d = 1'b0;
                        state_d    = ST_BUSY;
                    end else if (in_valid) begin
                        ex_valid_d  = 1'b1;
                        ex_result_d = alu_res;
                        ex_store_d  = operand_b;
                        ex_rw_d     = regwrite;
                        ex_mw_d     = memwrite;
                        ex_mtr_d    = memtoreg;
                        ex_br_d     = branch;
                        ex_wa_d     = write_addr;
                        if (setflags) begin
                            flags_d = {alu_res[XLEN-1], (alu_res == '0), alu_c, alu_v};
                        end
                    end else begin
                        ex_valid_d = 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (op_q == OP_MUL) begin
                        acc_d = acc_q + (b_q[0] ? a_q : '0);
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end else begin
                        acc_d = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
                        a_d   = {a_q[XLEN-2:0], rem_ge};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    ex_valid_d  = 1'b1;
                    ex_result_d = final_res;
                    ex_store_d  = store_q;
                    ex_rw_d     = rw_q;
                    ex_mw_d     = mw_q;
                    ex_mtr_d    = mtr_q;
                    ex_br_d     = br_q;
                    ex_wa_d     = wa_q;
                    if (sf_q) begin
                        flags_d = {final_res[XLEN-1], (final_res == '0), 2'b00};
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            store_q     <= '0;
            op_q        <= '0;
            rw_q        <= 1'b0;
            mw_q        <= 1'b0;
            mtr_q       <= 1'b0;
            br_q        <= 1'b0;
            sf_q        <= 1'b0;
            wa_q        <= '0;
            ex_valid_q  <= 1'b0;
            ex_result_q <= '0;
            ex_store_q  <= '0;
            ex_rw_q     <= 1'b0;
            ex_mw_q     <= 1'b0;
            ex_mtr_q    <= 1'b0;
            ex_br_q     <= 1'b0;
            ex_wa_q     <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            store_q     <= store_d;
            op_q        <= op_d;
            rw_q        <= rw_d;
            mw_q        <= mw_d;
            mtr_q       <= mtr_d;
            br_q        <= br_d;
            sf_q        <= sf_d;
            wa_q        <= wa_d;
            ex_valid_q  <= ex_valid_d;
            ex_result_q <= ex_result_d;
            ex_store_q  <= ex_store_d;
            ex_rw_q     <= ex_rw_d;
            ex_mw_q     <= ex_mw_d;
            ex_mtr_q    <= ex_mtr_d;
            ex_br_q     <= ex_br_d;
            ex_wa_q     <= ex_wa_d;
            flags_q     <= flags_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_result     = ex_result_q;
    assign ex_store_data = ex_store_q;
    assign ex_regwrite   = ex_rw_q;
    assign ex_memwrite   = ex_mw_q;
    assign ex_memtoreg   = ex_mtr_q;
    assign ex_branch     = ex_br_q;
    assign ex_write_addr = ex_wa_q;
    assign flags         = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed ops push expected results, a
// negedge monitor pops and compares whenever a fresh ex_valid result appears.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst, halt, in_valid;
    logic [63:0] operand_a, operand_b;
    logic [7:0]  aluop;
    logic        regwrite, memwrite, memtoreg, branch, setflags;
    logic [4:0]  write_addr;
    logic        stall, ex_valid;
    logic [63:0] ex_result, ex_store_data;
    logic        ex_regwrite, ex_memwrite, ex_memtoreg, ex_branch;
    logic [4:0]  ex_write_addr;
    logic [3:0]  flags;

    typedef struct {
        logic [63:0] res;
        logic [63:0] sd;
        logic [3:0]  fl;
        logic [3:0]  ctl;
        logic [4:0]  wa;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;
    logic halt_seen = 1'b0;

    execute_stage #(.XLEN(64), .ITER(64), .WADDR_W(5)) dut (
        .clk(clk), .rst(rst), .halt(halt), .in_valid(in_valid),
        .operand_a(operand_a), .operand_b(operand_b), .aluop(aluop),
        .regwrite(regwrite), .memwrite(memwrite), .memtoreg(memtoreg),
        .branch(branch), .setflags(setflags), .write_addr(write_addr),
        .stall(stall), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_regwrite(ex_regwrite),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_branch(ex_branch), .ex_write_addr(ex_write_addr), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge clk) halt_seen <= halt;

    // A result is fresh when ex_valid is high and the last edge was not halted.
    always @(negedge clk) begin
        if (!rst && ex_valid && !halt_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", ex_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: result=%h flags=%b wa=%0d", txn, ex_result, flags, ex_write_addr);
                chk("result", ex_result, e.res);
                chk("store_data", ex_store_data, e.sd);
                chk("flags", {60'd0, flags}, {60'd0, e.fl});
                chk("ctl", {60'd0, ex_regwrite, ex_memwrite, ex_memtoreg, ex_branch}, {60'd0, e.ctl});
                chk("write_addr", {59'd0, ex_write_addr}, {59'd0, e.wa});
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, {63'd0, ex_valid}, 64'd0);
        chk({tag, "_result"}, ex_result, 64'd0);
        chk({tag, "_store"}, ex_store_data, 64'd0);
        chk({tag, "_flags"}, {60'd0, flags}, 64'd0);
        chk({tag, "_ctl"}, {59'd0, ex_regwrite, ex_memwrite, ex_memtoreg, ex_branch, |ex_write_addr}, 64'd0);
    endtask

    // Issues one op at posedge+1, counts stall cycles, optionally pulses halt
    // for 3 cycles or asserts reset once the stall count reaches the given value.
    task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] ctl, input logic sf, input logic [4:0] wa,
                         input logic [63:0] res, input logic [3:0] fl,
                         input int exp_stall, input int halt_at, input int rst_at);
        exp_t e;
        int n = 0;
        logic aborted = 1'b0;
        logic [63:0] snap_res;
        logic [3:0]  snap_fl;
        logic        snap_v;
        aluop = op; operand_a = a; operand_b = b;
        {regwrite, memwrite, memtoreg, branch} = ctl;
        setflags = sf; write_addr = wa; in_valid = 1'b1;
        e.res = res; e.sd = b; e.fl = fl; e.ctl = ctl; e.wa = wa;
        exp_q.push_back(e);
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 300) begin
                chk("stall_timeout", 64'(n), 64'(exp_stall));
                break;
            end
            if (n == halt_at) begin
                halt = 1'b1;
                snap_res = ex_result; snap_fl = flags; snap_v = ex_valid;
                repeat (3) begin
                    @(negedge clk);
                    chk("halt_stall", {63'd0, stall}, 64'd1);
                    chk("halt_frozen", {ex_result ^ snap_res}, {60'd0, flags ^ snap_fl} | {63'd0, ex_valid ^ snap_v});
                    n++;
                end
                halt = 1'b0;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                chk_zero_outputs("rst_mid");
                rst = 1'b0;
                #1;
                chk("rst_release_stall", {63'd0, stall}, 64'd0);
                void'(exp_q.pop_back());
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) chk("stall_cycles", 64'(n), 64'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; halt = 1'b0; in_valid = 1'b0;
        operand_a = '0; operand_b = '0; aluop = '0;
        regwrite = 0; memwrite = 0; memtoreg = 0; branch = 0; setflags = 0; write_addr = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        #1;
        chk("reset_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;

        //    op     a                       b                       ctl     sf  wa  result                  flags   stall halt rst
        issue(8'h00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 4'b1000, 1, 3, 64'h8000_0000_0000_0000, 4'b1001, 0, -1, -1);
        issue(8'h01, 64'd5,                  64'd5,                 4'b1000, 0, 4, 64'd0,                   4'b1001, 0, -1, -1);
        issue(8'h01, 64'd3,                  64'd5,                 4'b1000, 1, 5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 0, -1, -1);
        issue(8'h01, 64'd5,                  64'd3,                 4'b0100, 1, 6, 64'd2,                   4'b0010, 0, -1, -1);
        issue(8'h05, 64'd1,                  64'd127,               4'b1000, 1, 7, 64'h8000_0000_0000_0000, 4'b1000, 0, -1, -1);
        issue(8'h06, 64'h8000_0000_0000_0000, 64'd4,                 4'b1010, 0, 8, 64'h0800_0000_0000_0000, 4'b1000, 0, -1, -1);
        issue(8'h07, 64'h8000_0000_0000_0000, 64'd4,                 4'b1000, 0, 9, 64'hF800_0000_0000_0000, 4'b1000, 0, -1, -1);
        issue(8'h04, 64'hFF00,               64'h0FF0,              4'b0001, 0, 10, 64'hF0F0,               4'b1000, 0, -1, -1);
        issue(8'h02, 64'hFF00,               64'h0FF0,              4'b1000, 0, 11, 64'h0F00,               4'b1000, 0, -1, -1);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_valid", {63'd0, ex_valid}, 64'd0);
        @(posedge clk); #1;
        issue(8'h03, 64'hFF00,               64'h0FF0,              4'b1000, 0, 12, 64'hFFF0,               4'b1000, 0, -1, -1);
        issue(8'h3F, 64'd5,                  64'd6,                 4'b1000, 1, 13, 64'd0,                  4'b0100, 0, -1, -1);
        issue(8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 4'b1000, 1, 14, 64'd0,                  4'b0110, 0, -1, -1);
        issue(8'h08, 64'h1_0000_0003,         64'd7,                 4'b1000, 1, 15, 64'h7_0000_0015,        4'b0000, 65, -1, -1);
        issue(8'h00, 64'd1,                  64'd1,                 4'b1000, 0, 16, 64'd2,                  4'b0000, 0, -1, -1);
        issue(8'h09, 64'd100,                64'd7,                 4'b1000, 0, 17, 64'd14,                 4'b0000, 65, -1, -1);
        issue(8'h0A, 64'd100,                64'd7,                 4'b1000, 0, 18, 64'd2,                  4'b0000, 65, -1, -1);
        issue(8'h09, 64'd9,                  64'd0,                 4'b1000, 1, 19, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 65, -1, -1);
        issue(8'h0A, 64'd9,                  64'd0,                 4'b1000, 0, 20, 64'd9,                  4'b1000, 65, -1, -1);
        issue(8'h08, 64'h1_0000_0003,         64'd7,                 4'b0110, 0, 21, 64'h7_0000_0015,        4'b1000, 68, 10, -1);
        issue(8'h09, 64'd1000,               64'd3,                 4'b1000, 1, 22, 64'd333,                4'b0000, 0, -1, 20);
        issue(8'h00, 64'd2,                  64'd3,                 4'b1000, 1, 23, 64'd5,                  4'b0000, 0, -1, -1);
        in_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
